// File: rtl/control_unit_pipe_pkg.sv
// ctrl_pkg: shared definitions for the registered RV32I control decode.
// Contents: opcode constants, ALU operation codes, operand-B select
// encodings, the stage FSM state type, the control bundle struct and
// the R/I-type funct3 -> ALU operation helper.
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MDU  = 7'b0000001;

  // ALU codes are kept 8 bits wide here and narrowed to ALUOP_W by the
  // decoder. M-ops use ALU_MUL_BASE + funct3, so they need ALUOP_W >= 5.
  localparam logic [7:0] ALU_ADD      = 8'd0;
  localparam logic [7:0] ALU_SUB      = 8'd1;
  localparam logic [7:0] ALU_SLL      = 8'd2;
  localparam logic [7:0] ALU_SLT      = 8'd3;
  localparam logic [7:0] ALU_SLTU     = 8'd4;
  localparam logic [7:0] ALU_XOR      = 8'd5;
  localparam logic [7:0] ALU_SRL      = 8'd6;
  localparam logic [7:0] ALU_SRA      = 8'd7;
  localparam logic [7:0] ALU_OR       = 8'd8;
  localparam logic [7:0] ALU_AND      = 8'd9;
  localparam logic [7:0] ALU_PASSB    = 8'd10;
  localparam logic [7:0] ALU_MUL_BASE = 8'd16;

  localparam logic [1:0] SRC_REG = 2'b00;
  localparam logic [1:0] SRC_IMM = 2'b01;
  localparam logic [1:0] SRC_PC  = 2'b10;

  typedef enum logic {
    ST_IDLE,
    ST_MDU_BUSY
  } state_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       rw_sel;
    logic       branch;
    logic       jump;
    logic [1:0] alu_src;
  } ctrl_t;

  // alt selects SUB for funct3=000 and SRA for funct3=101.
  function automatic logic [7:0] alu_from_funct3(input logic [2:0] f3,
                                                 input logic       alt);
    logic [7:0] code;
    code = ALU_AND;
    case (f3)
      3'b000:  code = alt ? ALU_SUB : ALU_ADD;
      3'b001:  code = ALU_SLL;
      3'b010:  code = ALU_SLT;
      3'b011:  code = ALU_SLTU;
      3'b100:  code = ALU_XOR;
      3'b101:  code = alt ? ALU_SRA : ALU_SRL;
      3'b110:  code = ALU_OR;
      default: code = ALU_AND;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/control_unit_pipe_decode.sv
// control_decode: purely combinational RV32I control decode.
// Ports:
//   opcode, funct3, funct7 : instruction fields
//   ctrl                   : control bundle (write/mem/branch/jump/src bits)
//   alu_op                 : ALU operation, ALUOP_W bits
//   is_mdu                 : instruction is an M-extension op
//   illegal                : fields do not form a decoded instruction
module control_decode
  import ctrl_pkg::*;
#(
  parameter int ALUOP_W = 4,
  parameter int MDU_EN  = 1
) (
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic [6:0]         funct7,
  output ctrl_t              ctrl,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               is_mdu,
  output logic               illegal
);

  logic [7:0] alu_code;

  // NOTE: every output of a combinational block gets a default before the
  // case statement; a path that skips an assignment would infer a latch.
  always_comb begin
    ctrl     = '0;
    alu_code = ALU_ADD;
    is_mdu   = 1'b0;
    illegal  = 1'b0;
    case (opcode)
      OP_R: begin
        // Only the base encodings and the SUB/SRA alternates are legal.
        if (funct7 == F7_BASE ||
            (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          ctrl.reg_write = 1'b1;
          ctrl.alu_src   = SRC_REG;
          alu_code       = alu_from_funct3(funct3, funct7[5]);
        end else if (MDU_EN != 0 && funct7 == F7_MDU) begin
          ctrl.reg_write = 1'b1;
          is_mdu         = 1'b1;
          alu_code       = ALU_MUL_BASE + {5'b0, funct3};
        end else begin
          illegal = 1'b1;
        end
      end
      OP_IMM: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = SRC_IMM;
        // There is no SUBI: funct7[5] only distinguishes SRAI from SRLI.
        alu_code = alu_from_funct3(funct3, (funct3 == 3'b101) && funct7[5]);
      end
      OP_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_src    = SRC_IMM;
      end
      OP_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = SRC_IMM;
      end
      OP_BRANCH: begin
        ctrl.branch  = 1'b1;
        ctrl.alu_src = SRC_REG;
        alu_code     = ALU_SUB;
      end
      OP_JAL: begin
        ctrl.jump      = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.rw_sel    = 1'b1;
        ctrl.alu_src   = SRC_PC;
      end
      OP_JALR: begin
        if (funct3 == 3'b000) begin
          ctrl.jump      = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.rw_sel    = 1'b1;
          ctrl.alu_src   = SRC_IMM;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = SRC_IMM;
        alu_code       = ALU_PASSB;
      end
      OP_AUIPC: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = SRC_PC;
      end
      default: illegal = 1'b1;
    endcase
  end

  assign alu_op = ALUOP_W'(alu_code);

endmodule

// File: rtl/control_unit_pipe.sv
// control_unit_pipe: registered, valid/ready control decode stage between
// IF/ID and execute, with flush and an M-extension busy sequencer.
// Ports:
//   clk, rst             : clock, asynchronous active-low reset
//   in_valid / in_ready  : upstream handshake (instruction fields)
//   opcode/funct3/funct7 : instruction fields
//   flush                : drop the held bundle and abort any MDU busy period
//   out_valid / out_ready: downstream handshake (control bundle)
//   RegWrite..Jump       : control bits
//   ALUOp, ALUSrc        : ALU operation and operand-B select
//   mdu_op, illegal      : M-extension op flag, undecodable instruction flag
module control_unit_pipe
  import ctrl_pkg::*;
#(
  parameter int ALUOP_W = 4,
  parameter int MDU_EN  = 1,
  parameter int MDU_LAT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic [6:0]         funct7,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               RegWrite,
  output logic               MemToReg,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               RWsel,
  output logic               Branch,
  output logic               Jump,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [1:0]         ALUSrc,
  output logic               mdu_op,
  output logic               illegal
);

  ctrl_t              dec_ctrl, ctrl_q;
  logic [ALUOP_W-1:0] dec_alu, alu_q;
  logic               dec_mdu, dec_ill, mdu_q, ill_q;
  state_t             state, state_next;
  logic [7:0]         cnt, cnt_next;
  logic               accept;

  control_decode #(
    .ALUOP_W (ALUOP_W),
    .MDU_EN  (MDU_EN)
  ) u_decode (
    .opcode  (opcode),
    .funct3  (funct3),
    .funct7  (funct7),
    .ctrl    (dec_ctrl),
    .alu_op  (dec_alu),
    .is_mdu  (dec_mdu),
    .illegal (dec_ill)
  );

  // Depends only on registered state and out_ready, never on in_valid.
  assign in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // NOTE: sequential state is written with non-blocking assignments so all
  // registers update together from the values sampled at the clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      ctrl_q    <= '0;
      alu_q     <= '0;
      mdu_q     <= 1'b0;
      ill_q     <= 1'b0;
    end else if (flush) begin
      // A same-cycle accept is dropped along with the held bundle.
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      ctrl_q    <= dec_ctrl;
      alu_q     <= dec_alu;
      mdu_q     <= dec_mdu;
      ill_q     <= dec_ill;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
    // Otherwise out_valid & !out_ready: the whole bundle holds.
  end

  // The busy period starts at the M-op accept; cnt counts MDU_LAT down and
  // the stage returns to IDLE on the edge after cnt reads 1, so in_ready is
  // low for exactly MDU_LAT cycles.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (flush) begin
      state_next = ST_IDLE;
      cnt_next   = 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept && dec_mdu) begin
            state_next = ST_MDU_BUSY;
            cnt_next   = 8'(MDU_LAT);
          end
        end
        ST_MDU_BUSY: begin
          if (cnt <= 8'd1) begin
            state_next = ST_IDLE;
            cnt_next   = 8'd0;
          end else begin
            cnt_next = cnt - 8'd1;
          end
        end
        default: begin
          state_next = ST_IDLE;
          cnt_next   = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  assign RegWrite = ctrl_q.reg_write;
  assign MemToReg = ctrl_q.mem_to_reg;
  assign MemRead  = ctrl_q.mem_read;
  assign MemWrite = ctrl_q.mem_write;
  assign RWsel    = ctrl_q.rw_sel;
  assign Branch   = ctrl_q.branch;
  assign Jump     = ctrl_q.jump;
  assign ALUSrc   = ctrl_q.alu_src;
  assign ALUOp    = alu_q;
  assign mdu_op   = mdu_q;
  assign illegal  = ill_q;

endmodule

// File: tb/tb_control_unit_pipe.sv
// Directed testbench for control_unit_pipe (ALUOP_W=5, MDU_EN=1, MDU_LAT=4).
module tb_control_unit_pipe;

  localparam int ALUOP_W = 5;
  localparam int MDU_LAT = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [6:0]         opcode = '0;
  logic [2:0]         funct3 = '0;
  logic [6:0]         funct7 = '0;
  logic               flush = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic               RegWrite, MemToReg, MemRead, MemWrite, RWsel, Branch, Jump;
  logic [ALUOP_W-1:0] ALUOp;
  logic [1:0]         ALUSrc;
  logic               mdu_op, illegal;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [16:0] obs;
  assign obs = {RegWrite, MemToReg, MemRead, MemWrite, RWsel, Branch, Jump,
                ALUSrc, ALUOp, mdu_op, illegal, out_valid};

  control_unit_pipe #(
    .ALUOP_W (ALUOP_W),
    .MDU_EN  (1),
    .MDU_LAT (MDU_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7    (funct7),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .RegWrite  (RegWrite),
    .MemToReg  (MemToReg),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .RWsel     (RWsel),
    .Branch    (Branch),
    .Jump      (Jump),
    .ALUOp     (ALUOp),
    .ALUSrc    (ALUSrc),
    .mdu_op    (mdu_op),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  // Expected-bundle packer, same field order as obs.
  function automatic logic [16:0] mk(input logic rw, m2r, mr, mw, rws, br, j,
                                     input logic [1:0] src, input logic [4:0] op,
                                     input logic mdu, ill, ov);
    return {rw, m2r, mr, mw, rws, br, j, src, op, mdu, ill, ov};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    in_valid = 1'b1;
    opcode   = op;
    funct3   = f3;
    funct7   = f7;
  endtask

  task automatic test_reset();
    logic [16:0] exp_v;
    exp_v = '0;
    #12;
    vec_cnt++;
    if (obs !== exp_v) begin
      $display("FAIL reset_outputs: got %h want %h", obs, exp_v);
      err_cnt++;
    end
    @(negedge clk);
    rst = 1'b1;
    step();
    vec_cnt++;
    if (in_ready !== 1'b1) begin
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
      err_cnt++;
    end
  endtask

  task automatic test_load();
    logic [16:0] exp_v;
    out_ready = 1'b1;
    drive(7'b0000011, 3'b010, 7'b0);
    step();
    in_valid = 1'b0;
    exp_v = mk(1, 1, 1, 0, 0, 0, 0, 2'b01, 5'd0, 0, 0, 1);
    vec_cnt++;
    if (obs !== exp_v) begin
      $display("FAIL load_bundle: got %h want %h", obs, exp_v);
      err_cnt++;
    end
    step();
    vec_cnt++;
    if (out_valid !== 1'b0) begin
      $display("FAIL load_drain: out_valid got %b want 0", out_valid);
      err_cnt++;
    end
  endtask

  task automatic test_stall();
    logic [16:0] exp_sub, exp_and;
    exp_sub = mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 5'd1, 0, 0, 1);
    exp_and = mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 5'd9, 0, 0, 1);
    out_ready = 1'b0;
    drive(7'b0110011, 3'b000, 7'b0100000);
    step();
    drive(7'b0110011, 3'b111, 7'b0000000);
    for (int i = 0; i < 3; i++) begin
      vec_cnt++;
      if (obs !== exp_sub || in_ready !== 1'b0) begin
        $display("FAIL stall_hold[%0d]: got %h rdy %b want %h rdy 0", i, obs, in_ready, exp_sub);
        err_cnt++;
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    vec_cnt++;
    if (in_ready !== 1'b1) begin
      $display("FAIL stall_release_ready: got %b want 1", in_ready);
      err_cnt++;
    end
    step();
    in_valid = 1'b0;
    vec_cnt++;
    if (obs !== exp_and) begin
      $display("FAIL stall_second: got %h want %h", obs, exp_and);
      err_cnt++;
    end
    step();
  endtask

  task automatic test_mdu();
    logic [16:0] exp_mul, exp_add;
    int n;
    exp_mul = mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 5'd16, 1, 0, 1);
    exp_add = mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 5'd0, 0, 0, 1);
    out_ready = 1'b1;
    drive(7'b0110011, 3'b000, 7'b0000001);
    step();
    vec_cnt++;
    if (obs !== exp_mul) begin
      $display("FAIL mdu_bundle: got %h want %h", obs, exp_mul);
      err_cnt++;
    end
    drive(7'b0110011, 3'b000, 7'b0000000);
    n = 0;
    while (in_ready === 1'b0 && n < 20) begin
      n++;
      step();
    end
    vec_cnt++;
    if (n !== MDU_LAT) begin
      $display("FAIL mdu_busy_cycles: got %0d want %0d", n, MDU_LAT);
      err_cnt++;
    end
    step();
    in_valid = 1'b0;
    vec_cnt++;
    if (obs !== exp_add) begin
      $display("FAIL mdu_next_add: got %h want %h", obs, exp_add);
      err_cnt++;
    end
    step();
  endtask

  task automatic test_illegal();
    logic [16:0] exp_v;
    exp_v = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 5'd0, 0, 1, 1);
    out_ready = 1'b1;
    drive(7'b1111111, 3'b000, 7'b0);
    step();
    in_valid = 1'b0;
    vec_cnt++;
    if (obs !== exp_v || in_ready !== 1'b1) begin
      $display("FAIL illegal_op: got %h rdy %b want %h rdy 1", obs, in_ready, exp_v);
      err_cnt++;
    end
    step();
  endtask

  task automatic test_decode_table();
    logic [6:0]  t_op [10];
    logic [2:0]  t_f3 [10];
    logic [6:0]  t_f7 [10];
    logic [16:0] t_ex [10];
    t_op[0] = 7'b0100011; t_f3[0] = 3'd2; t_f7[0] = 7'h00; t_ex[0] = mk(0,0,0,1,0,0,0,2'b01,5'd0,0,0,1);
    t_op[1] = 7'b1100011; t_f3[1] = 3'd0; t_f7[1] = 7'h00; t_ex[1] = mk(0,0,0,0,0,1,0,2'b00,5'd1,0,0,1);
    t_op[2] = 7'b0010011; t_f3[2] = 3'd5; t_f7[2] = 7'h20; t_ex[2] = mk(1,0,0,0,0,0,0,2'b01,5'd7,0,0,1);
    t_op[3] = 7'b0010011; t_f3[3] = 3'd0; t_f7[3] = 7'h20; t_ex[3] = mk(1,0,0,0,0,0,0,2'b01,5'd0,0,0,1);
    t_op[4] = 7'b0110111; t_f3[4] = 3'd0; t_f7[4] = 7'h00; t_ex[4] = mk(1,0,0,0,0,0,0,2'b01,5'd10,0,0,1);
    t_op[5] = 7'b0010111; t_f3[5] = 3'd0; t_f7[5] = 7'h00; t_ex[5] = mk(1,0,0,0,0,0,0,2'b10,5'd0,0,0,1);
    t_op[6] = 7'b1100111; t_f3[6] = 3'd0; t_f7[6] = 7'h00; t_ex[6] = mk(1,0,0,0,1,0,1,2'b01,5'd0,0,0,1);
    t_op[7] = 7'b1100111; t_f3[7] = 3'd1; t_f7[7] = 7'h00; t_ex[7] = mk(0,0,0,0,0,0,0,2'b00,5'd0,0,1,1);
    t_op[8] = 7'b0110011; t_f3[8] = 3'd1; t_f7[8] = 7'h20; t_ex[8] = mk(0,0,0,0,0,0,0,2'b00,5'd0,0,1,1);
    t_op[9] = 7'b0110011; t_f3[9] = 3'd3; t_f7[9] = 7'h00; t_ex[9] = mk(1,0,0,0,0,0,0,2'b00,5'd4,0,0,1);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(t_op[i], t_f3[i], t_f7[i]);
      step();
      vec_cnt++;
      if (obs !== t_ex[i]) begin
        $display("FAIL decode_table[%0d]: got %h want %h", i, obs, t_ex[i]);
        err_cnt++;
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(7'b0110011, 3'b000, 7'b0000001);
    step();
    in_valid = 1'b0;
    step();
    step();
    flush = 1'b1;
    #1;
    vec_cnt++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      $display("FAIL flush_pre: ov %b rdy %b want ov 1 rdy 0", out_valid, in_ready);
      err_cnt++;
    end
    step();
    flush = 1'b0;
    vec_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL flush_busy: ov %b rdy %b want ov 0 rdy 1", out_valid, in_ready);
      err_cnt++;
    end
    out_ready = 1'b1;
    drive(7'b0000011, 3'b010, 7'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    vec_cnt++;
    if (out_valid !== 1'b0) begin
      $display("FAIL flush_drop_accept: ov %b want 0", out_valid);
      err_cnt++;
    end
    step();
  endtask

  task automatic test_async_reset();
    logic [16:0] exp_jal;
    exp_jal = mk(1, 0, 0, 0, 1, 0, 1, 2'b10, 5'd0, 0, 0, 1);
    out_ready = 1'b0;
    drive(7'b0000011, 3'b010, 7'b0);
    step();
    in_valid = 1'b0;
    vec_cnt++;
    if (out_valid !== 1'b1) begin
      $display("FAIL areset_pre: ov %b want 1", out_valid);
      err_cnt++;
    end
    #2;
    rst = 1'b0;
    #1;
    vec_cnt++;
    if (obs !== 17'h0) begin
      $display("FAIL areset_clear: got %h want 00000", obs);
      err_cnt++;
    end
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    step();
    drive(7'b1101111, 3'b000, 7'b0);
    step();
    in_valid = 1'b0;
    vec_cnt++;
    if (obs !== exp_jal) begin
      $display("FAIL areset_jal: got %h want %h", obs, exp_jal);
      err_cnt++;
    end
    step();
  endtask

  initial begin
    test_reset();
    test_load();
    test_stall();
    test_mdu();
    test_illegal();
    test_decode_table();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/control_unit_pipe.md
Name: control_unit_pipe

Overview:
- Registered, handshaked successor to the combinational control decode.
- Decodes RV32I opcode/funct3/funct7 into the same control bundle: RegWrite, MemToReg, MemRead, MemWrite, ALUOp, ALUSrc, RWsel, Branch, Jump.
- Adds a valid/ready pipeline stage, a flush input, illegal-instruction detection, and an optional M-extension multi-cycle sequencer.
- Sits between the IF/ID register and the execute stage.

Parameters:
- ALUOP_W, 4: ALUOp width; must be ≥4.
- MDU_EN, 1: 1 decodes M-extension (R-type with funct7=0000001); 0 treats it as illegal.
- MDU_LAT, 8: cycles the stage stays busy after issuing an MDU op; range 1..255.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  stage can accept.
- opcode  in  7  instruction[6:0].
- funct3  in  3  instruction[14:12].
- funct7  in  7  instruction[31:25].
- flush  in  1  kill the held bundle and abort any MDU busy period.
- out_valid  out  1  control bundle valid.
- out_ready  in  1  execute stage accepts.
- RegWrite, MemToReg, MemRead, MemWrite, RWsel, Branch, Jump  out  1 each  control bits.
- ALUOp  out  ALUOP_W  ALU operation.
- ALUSrc  out  2  operand B select: 00 register, 01 immediate, 10 PC.
- mdu_op  out  1  bundle is an M-extension op.
- illegal  out  1  opcode/funct combination not decoded.

Behaviour:
- Reset (rst=0, asynchronous): every output register is cleared to 0 (all control bits, ALUOp, ALUSrc, mdu_op, illegal, out_valid). FSM goes to IDLE; busy counter is 0. in_ready=1 once rst deasserts.
- Latency: one cycle. A bundle accepted on edge N (in_valid & in_ready) drives out_valid=1 after edge N.
- in_ready = (state==IDLE) & (!out_valid | out_ready). This is combinational and has no path from in_valid.
- Hold rule: while out_valid & !out_ready, every output is held stable.
- On a transfer with no new accept, out_valid falls to 0 on the next edge.
- Decode (ALUOp codes are defined in the package):
  - R-type 0110011: RegWrite=1, ALUSrc=00. ALUOp comes from funct3, with funct7[5] selecting SUB/SRA.
  - I-ALU 0010011: RegWrite=1, ALUSrc=01. funct7[5] is used only for SRAI.
  - LOAD 0000011: RegWrite=1, MemRead=1, MemToReg=1, ALUSrc=01, ALUOp=ADD.
  - STORE 0100011: MemWrite=1, ALUSrc=01, ALUOp=ADD.
  - BRANCH 1100011: Branch=1, ALUSrc=00, ALUOp=SUB.
  - JAL 1101111: Jump=1, RegWrite=1, RWsel=1, ALUSrc=10, ALUOp=ADD.
  - JALR 1100111 with funct3=000: Jump=1, RegWrite=1, RWsel=1, ALUSrc=01, ALUOp=ADD.
  - LUI 0110111: RegWrite=1, ALUSrc=01, ALUOp=PASSB.
  - AUIPC 0010111: RegWrite=1, ALUSrc=10, ALUOp=ADD.
  - M-op (R-type, funct7=0000001, MDU_EN=1): RegWrite=1, mdu_op=1, ALUOp = MUL_BASE + funct3.
  - Anything else: illegal=1, all write/mem/branch/jump bits 0, ALUOp=0. The bundle is still emitted with out_valid=1 and does not stall.
- FSM states:
  - IDLE → MDU_BUSY when an M-op is accepted; cnt is loaded with MDU_LAT.
  - In MDU_BUSY, cnt decrements each cycle and in_ready=0.
  - MDU_BUSY → IDLE on the edge where cnt reaches 1, so accepts resume exactly MDU_LAT cycles after the M-op accept.
  - The M-op bundle itself follows the normal out_valid/out_ready rules during MDU_BUSY.
- Flush (synchronous, highest priority):
  - Next edge: out_valid=0, state=IDLE, cnt=0.
  - Any accept in the same cycle is discarded.
  - in_ready is unaffected by flush in the cycle it is asserted.
- Reset mid-operation (mid-busy or mid-stall): returns immediately to the reset state; the held bundle is lost.
- Cross-cycle note: in_ready=0 whenever state≠IDLE, even if out_ready=1.

Decomposition:
- Package ctrl_pkg holds:
  - opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC)
  - ALUOp codes: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASSB=10, MUL_BASE=ALUOP_W'(16) (M-ops use MUL_BASE+funct3 and require ALUOP_W≥5 when MDU_EN=1)
  - ALUSrc encodings
  - FSM state enum
- Sub-module control_decode: purely combinational fields → bundle + illegal + is_mdu. The top holds the pipe register, handshake, FSM and counter.

Test Plan:
- Reset then LOAD (opcode 0000011), out_ready=1: one cycle later out_valid=1, RegWrite=1, MemRead=1, MemToReg=1, ALUSrc=01, ALUOp=0, illegal=0.
- R-type SUB (funct7=0100000, funct3=000) with out_ready=0 for 3 cycles: bundle held stable with ALUOp=1; in_ready=0 until out_ready=1; second instruction accepted the same cycle.
- MUL (funct7=0000001, funct3=000), MDU_LAT=4, out_ready=1: mdu_op=1, ALUOp=16; in_ready=0 for exactly 4 cycles; next ADD accepted on the 5th.
- Opcode 1111111: out_valid=1, illegal=1, RegWrite=MemWrite=Branch=Jump=0; no stall.
- Flush asserted during MDU_BUSY with cnt=2: next edge out_valid=0, in_ready=1.
- rst pulled low asynchronously mid-stall: all outputs 0 without a clock edge; after release, JAL decodes to Jump=1, RWsel=1, ALUSrc=10.
